// File: rtl/demod_pkg.sv
// Shared constants and types for the QPD demodulator low-pass filter engine.
// Holds the default 41-tap symmetric low-pass coefficient set (Q1.23), the
// scheduler state type and the derived datapath widths.
package demod_pkg;

    localparam int unsigned DEMOD_NUM_BITS   = 24;
    localparam int unsigned DEMOD_NUM_TAPS   = 41;
    localparam int unsigned DEMOD_NUM_CH     = 4;
    localparam int unsigned DEMOD_COEFF_FRAC = 23;

    localparam int unsigned TAP_IDX_BITS = $clog2(DEMOD_NUM_TAPS);
    // Full-precision product plus growth for the tap sum; cannot overflow.
    localparam int unsigned ACC_BITS     = 2 * DEMOD_NUM_BITS + TAP_IDX_BITS;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        MAC,
        DRAIN,
        STORE,
        DONE
    } sched_state_e;

    // Symmetric about tap 20; index 0 multiplies the newest sample.
    localparam logic signed [DEMOD_NUM_BITS-1:0] DEMOD_LPF_COEFFS [DEMOD_NUM_TAPS] = '{
        -24'sd1160,    -24'sd4252,    -24'sd5988,    -24'sd250,      24'sd14454,
         24'sd30112,    24'sd28660,   -24'sd8218,    -24'sd61304,   -24'sd88836,
        -24'sd41012,    24'sd79880,    24'sd189504,   24'sd168944,  -24'sd33570,
        -24'sd285016,  -24'sd350098,  -24'sd21734,    24'sd632842,   24'sd1402104,
         24'sd2487678,
         24'sd1402104,  24'sd632842,  -24'sd21734,   -24'sd350098,  -24'sd285016,
        -24'sd33570,    24'sd168944,   24'sd189504,   24'sd79880,   -24'sd41012,
        -24'sd88836,   -24'sd61304,   -24'sd8218,     24'sd28660,    24'sd30112,
         24'sd14454,   -24'sd250,     -24'sd5988,    -24'sd4252,    -24'sd1160
    };

endpackage

// File: rtl/demod_mac_pipe.sv
// Two-stage multiply/accumulate shared by all filter channels.
// Stage 1 registers the operands, stage 2 registers the full-width product,
// then the product is added into the accumulator. The result output is the
// accumulator shifted down by the coefficient fraction (floor) and saturated.
module demod_mac_pipe
    import demod_pkg::*;
#(
    parameter int unsigned NUM_BITS   = DEMOD_NUM_BITS,
    parameter int unsigned ACC_W      = ACC_BITS,
    parameter int unsigned COEFF_FRAC = DEMOD_COEFF_FRAC
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       issue,
    input  logic signed [NUM_BITS-1:0] sample,
    input  logic signed [NUM_BITS-1:0] coeff,
    input  logic                       clear,
    output logic signed [NUM_BITS-1:0] result
);

    logic signed [NUM_BITS-1:0]   op_a;
    logic signed [NUM_BITS-1:0]   op_b;
    logic                         op_valid;
    logic signed [2*NUM_BITS-1:0] prod;
    logic                         prod_valid;
    logic signed [ACC_W-1:0]      acc;
    logic signed [ACC_W-1:0]      shifted;
    logic [ACC_W-NUM_BITS:0]      top_bits;

    // Operand and product pipeline registers with their valid flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a       <= '0;
            op_b       <= '0;
            op_valid   <= 1'b0;
            prod       <= '0;
            prod_valid <= 1'b0;
        end else begin
            op_valid   <= issue;
            prod_valid <= op_valid;
            if (issue) begin
                op_a <= sample;
                op_b <= coeff;
            end
            if (op_valid) begin
                prod <= (2*NUM_BITS)'(op_a) * (2*NUM_BITS)'(op_b);
            end
        end
    end

    // Accumulator; clear has priority so a new channel always starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (prod_valid) begin
            acc <= acc + ACC_W'(prod);
        end
    end

    assign shifted  = acc >>> COEFF_FRAC;
    assign top_bits = shifted[ACC_W-1:NUM_BITS-1];

    // Saturate when the bits above the output sign are not all sign copies.
    always_comb begin
        result = shifted[NUM_BITS-1:0];
        if (!((&top_bits) || !(|top_bits))) begin
            if (shifted[ACC_W-1]) begin
                result = {1'b1, {(NUM_BITS-1){1'b0}}};
            end else begin
                result = {1'b0, {(NUM_BITS-1){1'b1}}};
            end
        end
    end

endmodule

// File: rtl/demod_fir_scheduler.sv
// Time-multiplexed low-pass FIR engine for the QPD demodulator.
// One tick captures four mixer products into per-channel history rings, then
// a single MAC pipeline runs NUM_TAPS taps per channel; all four outputs are
// published together with a one-cycle done pulse.
// Build option: define DEMOD_SCHED_COEFF_WR_EN to make the coefficient bank
// writable; otherwise coefficients are the package constants and the write
// port is ignored.
module demod_fir_scheduler
    import demod_pkg::*;
#(
    parameter int unsigned NUM_BITS   = DEMOD_NUM_BITS,
    parameter int unsigned NUM_TAPS   = DEMOD_NUM_TAPS,
    parameter int unsigned NUM_CH     = DEMOD_NUM_CH,
    parameter int unsigned COEFF_FRAC = DEMOD_COEFF_FRAC
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic                          tick_i,
    input  logic [NUM_CH*NUM_BITS-1:0]    ch_i,
    input  logic                          coeff_we_i,
    input  logic [$clog2(NUM_TAPS)-1:0]   coeff_addr_i,
    input  logic signed [NUM_BITS-1:0]    coeff_data_i,
    input  logic                          overrun_clr_i,
    output logic [NUM_CH*NUM_BITS-1:0]    y_o,
    output logic                          done_o,
    output logic                          busy_o,
    output logic                          overrun_o
);

    localparam int unsigned IDX_W = $clog2(NUM_TAPS);
    localparam int unsigned ACC_W = 2 * NUM_BITS + IDX_W;
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(NUM_TAPS - 1);
    localparam logic [IDX_W-1:0] TAPS_MOD = IDX_W'(NUM_TAPS);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

    sched_state_e               state;
    logic [IDX_W-1:0]           wr_ptr;
    logic [IDX_W-1:0]           k;
    logic [IDX_W-1:0]           rd_idx;
    logic [CH_W-1:0]            ch;
    logic                       drain_cnt;
    logic                       busy;
    logic                       done;
    logic                       overrun;
    logic [NUM_CH*NUM_BITS-1:0] y;

    logic signed [NUM_BITS-1:0] hist      [NUM_CH][NUM_TAPS];
    logic signed [NUM_BITS-1:0] ch_result [NUM_CH];
    logic signed [NUM_BITS-1:0] coeff_k;
    logic signed [NUM_BITS-1:0] mac_result;
    logic                       start;

    assign start = (state == IDLE) && tick_i;

    // Ring read index (wr_ptr - k) mod NUM_TAPS; the wrapped sum always fits IDX_W.
    always_comb begin
        if (wr_ptr >= k) begin
            rd_idx = wr_ptr - k;
        end else begin
            rd_idx = wr_ptr - k + TAPS_MOD;
        end
    end

    // History rings: samples land at wr_ptr on an accepted tick only.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int t = 0; t < NUM_TAPS; t++) begin
                    hist[c][t] <= '0;
                end
            end
        end else if (start) begin
            for (int c = 0; c < NUM_CH; c++) begin
                hist[c][wr_ptr] <= ch_i[c*NUM_BITS +: NUM_BITS];
            end
        end
    end

`ifdef DEMOD_SCHED_COEFF_WR_EN
    logic signed [NUM_BITS-1:0] coeff [NUM_TAPS];

    // Coefficient bank; writes only land while idle and in range.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int t = 0; t < NUM_TAPS; t++) begin
                coeff[t] <= NUM_BITS'(DEMOD_LPF_COEFFS[t]);
            end
        end else if ((state == IDLE) && coeff_we_i && (32'(coeff_addr_i) < NUM_TAPS)) begin
            coeff[coeff_addr_i] <= coeff_data_i;
        end
    end

    assign coeff_k = coeff[k];
`else
    logic unused_coeff_port;

    assign coeff_k           = NUM_BITS'(DEMOD_LPF_COEFFS[k]);
    assign unused_coeff_port = ^{coeff_we_i, coeff_addr_i, coeff_data_i};
`endif

    demod_mac_pipe #(
        .NUM_BITS   (NUM_BITS),
        .ACC_W      (ACC_W),
        .COEFF_FRAC (COEFF_FRAC)
    ) u_mac (
        .clk    (clk_i),
        .rst_n  (reset_ni),
        .issue  (state == MAC),
        .sample (hist[ch][rd_idx]),
        .coeff  (coeff_k),
        .clear  (state == STORE),
        .result (mac_result)
    );

    // Scheduler FSM with registered busy/done/overrun and output bank.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            k         <= '0;
            ch        <= '0;
            drain_cnt <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            y         <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                ch_result[c] <= '0;
            end
        end else begin
            done <= 1'b0;

            // A tick that cannot be served sets the flag; setting beats clearing.
            if (tick_i && (state != IDLE)) begin
                overrun <= 1'b1;
            end else if (overrun_clr_i) begin
                overrun <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (tick_i) begin
                        busy  <= 1'b1;
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    ch    <= '0;
                    k     <= '0;
                    state <= MAC;
                end
                MAC: begin
                    if (k == LAST_TAP) begin
                        k         <= '0;
                        drain_cnt <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        k <= k + IDX_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt) begin
                        state <= STORE;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                STORE: begin
                    ch_result[ch] <= mac_result;
                    if (ch == LAST_CH) begin
                        state <= DONE;
                    end else begin
                        ch    <= ch + CH_W'(1);
                        state <= MAC;
                    end
                end
                DONE: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        y[c*NUM_BITS +: NUM_BITS] <= ch_result[c];
                    end
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    wr_ptr <= (wr_ptr == LAST_TAP) ? '0 : wr_ptr + IDX_W'(1);
                    state  <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign y_o       = y;
    assign done_o    = done;
    assign busy_o    = busy;
    assign overrun_o = overrun;

endmodule

// File: tb/tb_demod_fir_scheduler.sv
// Self-checking bench for demod_fir_scheduler. A behavioural model keeps each
// channel's last 41 samples newest-first and computes the filter as a plain
// dot product with floor shift and saturation.
module tb_demod_fir_scheduler;

    localparam int NB  = 24;
    localparam int NT  = 41;
    localparam int NC  = 4;
    localparam int LAT = 178;

    localparam int DEFAULT_COEFFS [NT] = '{
        -1160, -4252, -5988, -250, 14454, 30112, 28660, -8218, -61304, -88836,
        -41012, 79880, 189504, 168944, -33570, -285016, -350098, -21734, 632842, 1402104,
        2487678,
        1402104, 632842, -21734, -350098, -285016, -33570, 168944, 189504, 79880, -41012,
        -88836, -61304, -8218, 28660, 30112, 14454, -250, -5988, -4252, -1160
    };

    logic        clk = 1'b0;
    logic        reset_ni;
    logic        tick_i;
    logic [95:0] ch_i;
    logic        coeff_we_i;
    logic [5:0]  coeff_addr_i;
    logic [23:0] coeff_data_i;
    logic        overrun_clr_i;
    logic [95:0] y_o;
    logic        done_o;
    logic        busy_o;
    logic        overrun_o;

    int checks   = 0;
    int failures = 0;

    int hist_m [NC][NT];
    int coef_m [NT];

    always #5 clk = ~clk;

    demod_fir_scheduler dut (
        .clk_i         (clk),
        .reset_ni      (reset_ni),
        .tick_i        (tick_i),
        .ch_i          (ch_i),
        .coeff_we_i    (coeff_we_i),
        .coeff_addr_i  (coeff_addr_i),
        .coeff_data_i  (coeff_data_i),
        .overrun_clr_i (overrun_clr_i),
        .y_o           (y_o),
        .done_o        (done_o),
        .busy_o        (busy_o),
        .overrun_o     (overrun_o)
    );

    function automatic void model_reset();
        for (int c = 0; c < NC; c++) for (int t = 0; t < NT; t++) hist_m[c][t] = 0;
        for (int t = 0; t < NT; t++) coef_m[t] = DEFAULT_COEFFS[t];
    endfunction

    function automatic void model_tick(input logic [95:0] s);
        logic [23:0] v;
        for (int c = 0; c < NC; c++) begin
            for (int t = NT - 1; t > 0; t--) hist_m[c][t] = hist_m[c][t-1];
            v = s[c*NB +: NB];
            hist_m[c][0] = int'(signed'(v));
        end
    endfunction

    function automatic logic [95:0] model_y();
        logic [95:0] r;
        longint acc;
        longint q;
        r = '0;
        for (int c = 0; c < NC; c++) begin
            acc = 0;
            for (int t = 0; t < NT; t++) acc += longint'(hist_m[c][t]) * longint'(coef_m[t]);
            q = acc >>> 23;
            if (q > 64'sd8388607) q = 64'sd8388607;
            if (q < -64'sd8388608) q = -64'sd8388608;
            r[c*NB +: NB] = q[23:0];
        end
        return r;
    endfunction

    function automatic logic [95:0] pack4(input int a, input int b, input int c, input int d);
        logic [95:0] r;
        r[23:0]  = a[23:0];
        r[47:24] = b[23:0];
        r[71:48] = c[23:0];
        r[95:72] = d[23:0];
        return r;
    endfunction

    task automatic write_coeff(input logic [5:0] a, input logic [23:0] d);
        @(negedge clk);
        coeff_we_i = 1'b1; coeff_addr_i = a; coeff_data_i = d;
        @(posedge clk); #1;
        coeff_we_i = 1'b0;
    endtask

    // One tick and wait for done. wr_at: 0 writes with the tick, n>0 writes n cycles later.
    task automatic do_run(input logic [95:0] samp, input int wr_at, input logic [5:0] wa,
                          input logic [23:0] wd, output int lat, output logic [95:0] yobs,
                          output logic extra);
        @(negedge clk);
        ch_i = samp; tick_i = 1'b1;
        coeff_addr_i = wa; coeff_data_i = wd; coeff_we_i = (wr_at == 0);
        @(posedge clk); #1;
        tick_i = 1'b0; coeff_we_i = 1'b0;
        lat = -1; yobs = '0; extra = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk); #1;
            coeff_we_i = (n == wr_at);
            if (done_o === 1'b1) begin lat = n; yobs = y_o; break; end
        end
        coeff_we_i = 1'b0;
        @(posedge clk); #1;
        extra = done_o;
    endtask

    task automatic test_reset();
        reset_ni = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (y_o !== '0) begin failures++; $display("FAIL reset_y got=%h want=0", y_o); end
        checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy_o); end
        checks++; if (overrun_o !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b want=0", overrun_o); end
        @(negedge clk); reset_ni = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b want=0", busy_o); end
        model_reset();
    endtask

    task automatic test_impulse(input int runs);
        int exp0 [5] = '{-580, -2126, -2994, -125, 7227};
        int lat; logic [95:0] yobs, s, e; logic extra; logic [23:0] y0;
        for (int j = 0; j < runs; j++) begin
            s = pack4((j == 0) ? 4194304 : 0, 0, 0, 0);
            do_run(s, -1, 6'd0, 24'd0, lat, yobs, extra);
            model_tick(s);
            e = model_y();
            checks++; if (lat != LAT) begin failures++; $display("FAIL impulse_latency run=%0d got=%0d want=%0d", j, lat, LAT); end
            checks++; if (yobs !== e) begin failures++; $display("FAIL impulse_y run=%0d got=%h want=%h", j, yobs, e); end
            checks++; if (extra !== 1'b0) begin failures++; $display("FAIL impulse_done_width run=%0d got=%b want=0", j, extra); end
            if (j < 5) begin
                y0 = yobs[23:0];
                checks++;
                if (int'(signed'(y0)) != exp0[j]) begin
                    failures++; $display("FAIL impulse_y0_const run=%0d got=%0d want=%0d", j, int'(signed'(y0)), exp0[j]);
                end
            end
        end
    endtask

    task automatic test_random();
        int lat; logic [95:0] yobs, s, e; logic extra;
        for (int j = 0; j < 8; j++) begin
            s = {$urandom, $urandom, $urandom};
            do_run(s, -1, 6'd0, 24'd0, lat, yobs, extra);
            model_tick(s);
            e = model_y();
            checks++; if (lat != LAT) begin failures++; $display("FAIL random_latency run=%0d got=%0d want=%0d", j, lat, LAT); end
            checks++; if (yobs !== e) begin failures++; $display("FAIL random_y run=%0d got=%h want=%h", j, yobs, e); end
        end
    endtask

    task automatic test_overrun();
        int lat, ndone; logic [95:0] yobs, s, e;
        s = {$urandom, $urandom, $urandom};
        @(negedge clk); ch_i = s; tick_i = 1'b1;
        @(posedge clk); #1; tick_i = 1'b0;
        model_tick(s);
        lat = -1; ndone = 0; yobs = '0;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk); #1;
            tick_i = 1'b0;
            if (n == 1) begin
                checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL run_busy got=%b want=1", busy_o); end
            end
            if (n == 49) begin
                checks++; if (overrun_o !== 1'b0) begin failures++; $display("FAIL overrun_early got=%b want=0", overrun_o); end
                ch_i = {$urandom, $urandom, $urandom};
                tick_i = 1'b1;
            end
            if (n == 50) begin
                checks++; if (overrun_o !== 1'b1) begin failures++; $display("FAIL overrun_set got=%b want=1", overrun_o); end
            end
            if (n == 179) begin
                checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL run_busy_end got=%b want=0", busy_o); end
            end
            if (done_o === 1'b1) begin
                ndone++;
                if (lat < 0) begin lat = n; yobs = y_o; end
            end
        end
        e = model_y();
        checks++; if (lat != LAT) begin failures++; $display("FAIL overrun_latency got=%0d want=%0d", lat, LAT); end
        checks++; if (ndone != 1) begin failures++; $display("FAIL overrun_done_count got=%0d want=1", ndone); end
        checks++; if (yobs !== e) begin failures++; $display("FAIL overrun_y got=%h want=%h", yobs, e); end
        checks++; if (overrun_o !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%b want=1", overrun_o); end
        @(negedge clk); overrun_clr_i = 1'b1;
        @(posedge clk); #1; overrun_clr_i = 1'b0;
        checks++; if (overrun_o !== 1'b0) begin failures++; $display("FAIL overrun_clear got=%b want=0", overrun_o); end

        // Second run: a tick during the DONE cycle together with a clear.
        s = {$urandom, $urandom, $urandom};
        @(negedge clk); ch_i = s; tick_i = 1'b1;
        @(posedge clk); #1; tick_i = 1'b0;
        model_tick(s);
        lat = -1; ndone = 0; yobs = '0;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk); #1;
            tick_i = 1'b0; overrun_clr_i = 1'b0;
            if (n == 177) begin tick_i = 1'b1; overrun_clr_i = 1'b1; end
            if (n == 178) begin
                checks++; if (overrun_o !== 1'b1) begin failures++; $display("FAIL overrun_set_wins got=%b want=1", overrun_o); end
                overrun_clr_i = 1'b1;
            end
            if (n == 179) begin
                checks++; if (overrun_o !== 1'b0) begin failures++; $display("FAIL overrun_clear2 got=%b want=0", overrun_o); end
            end
            if (done_o === 1'b1) begin
                ndone++;
                if (lat < 0) begin lat = n; yobs = y_o; end
            end
        end
        e = model_y();
        checks++; if (lat != LAT) begin failures++; $display("FAIL done_tick_latency got=%0d want=%0d", lat, LAT); end
        checks++; if (ndone != 1) begin failures++; $display("FAIL done_tick_count got=%0d want=1", ndone); end
        checks++; if (yobs !== e) begin failures++; $display("FAIL done_tick_y got=%h want=%h", yobs, e); end
    endtask

    task automatic test_write_busy();
        int lat; logic [95:0] yobs, s, e; logic extra;
        s = {$urandom, $urandom, $urandom};
        do_run(s, 60, 6'd0, 24'h3fffff, lat, yobs, extra);
        model_tick(s);
        e = model_y();
        checks++; if (lat != LAT) begin failures++; $display("FAIL wr_busy_latency got=%0d want=%0d", lat, LAT); end
        checks++; if (yobs !== e) begin failures++; $display("FAIL wr_busy_y got=%h want=%h", yobs, e); end
        s = {$urandom, $urandom, $urandom};
        do_run(s, -1, 6'd0, 24'd0, lat, yobs, extra);
        model_tick(s);
        e = model_y();
        checks++; if (yobs !== e) begin failures++; $display("FAIL wr_busy_next_y got=%h want=%h", yobs, e); end
    endtask

`ifdef DEMOD_SCHED_COEFF_WR_EN
    task automatic test_gain();
        int lat; logic [95:0] yobs, s, e, want; logic extra;
        for (int t = 1; t < NT; t++) begin
            write_coeff(6'(t), 24'd0);
            coef_m[t] = 0;
        end
        write_coeff(6'd41, 24'h7fffff);
        write_coeff(6'd63, 24'h7fffff);
        // Write of tap 0 coincides with the tick and must be used by this run.
        s = pack4(1000000, 1000000, 1000000, 1000000);
        do_run(s, 0, 6'd0, 24'd8388607, lat, yobs, extra);
        coef_m[0] = 8388607;
        model_tick(s);
        e = model_y();
        want = pack4(999999, 999999, 999999, 999999);
        checks++; if (yobs !== e) begin failures++; $display("FAIL gain_pos_model got=%h want=%h", yobs, e); end
        checks++; if (yobs !== want) begin failures++; $display("FAIL gain_pos_const got=%h want=%h", yobs, want); end
        s = pack4(-1000000, -1000000, -1000000, -1000000);
        do_run(s, -1, 6'd0, 24'd0, lat, yobs, extra);
        model_tick(s);
        e = model_y();
        want = pack4(-1000000, -1000000, -1000000, -1000000);
        checks++; if (yobs !== e) begin failures++; $display("FAIL gain_neg_model got=%h want=%h", yobs, e); end
        checks++; if (yobs !== want) begin failures++; $display("FAIL gain_neg_const got=%h want=%h", yobs, want); end
    endtask

    task automatic test_saturation();
        int lat; logic [95:0] yobs, s, e, want; logic extra;
        for (int t = 0; t < NT; t++) begin
            write_coeff(6'(t), 24'd8388607);
            coef_m[t] = 8388607;
        end
        for (int pass = 0; pass < 2; pass++) begin
            s = (pass == 0) ? pack4(8388607, 8388607, 8388607, 8388607)
                            : pack4(-8388608, -8388608, -8388608, -8388608);
            for (int j = 0; j < NT; j++) begin
                do_run(s, -1, 6'd0, 24'd0, lat, yobs, extra);
                model_tick(s);
                e = model_y();
                checks++; if (yobs !== e) begin failures++; $display("FAIL sat_model pass=%0d run=%0d got=%h want=%h", pass, j, yobs, e); end
            end
            want = s;
            checks++; if (yobs !== want) begin failures++; $display("FAIL sat_const pass=%0d got=%h want=%h", pass, yobs, want); end
        end
    endtask
`else
    task automatic test_write_ignored();
        int lat; logic [95:0] yobs, s, e; logic extra;
        write_coeff(6'd20, 24'd0);
        write_coeff(6'd1, 24'h7fffff);
        for (int j = 0; j < 3; j++) begin
            s = {$urandom, $urandom, $urandom};
            do_run(s, (j == 0) ? 0 : -1, 6'd0, 24'h7fffff, lat, yobs, extra);
            model_tick(s);
            e = model_y();
            checks++; if (yobs !== e) begin failures++; $display("FAIL wr_ignored_y run=%0d got=%h want=%h", j, yobs, e); end
        end
    endtask
`endif

    task automatic test_reset_mid_run();
        int ndone; logic [95:0] s;
        s = {$urandom, $urandom, $urandom};
        @(negedge clk); ch_i = s; tick_i = 1'b1;
        @(posedge clk); #1; tick_i = 1'b0;
        repeat (100) @(posedge clk);
        #3; reset_ni = 1'b0;
        #1;
        checks++; if (y_o !== '0) begin failures++; $display("FAIL midrst_y got=%h want=0", y_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b want=0", busy_o); end
        checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b want=0", done_o); end
        @(negedge clk); reset_ni = 1'b1;
        model_reset();
        ndone = 0;
        repeat (250) begin
            @(posedge clk); #1;
            if (done_o === 1'b1) ndone++;
        end
        checks++; if (ndone != 0) begin failures++; $display("FAIL midrst_no_done got=%0d want=0", ndone); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL midrst_idle got=%b want=0", busy_o); end
        test_impulse(6);
    endtask

    initial begin
        reset_ni = 1'b0; tick_i = 1'b0; ch_i = '0; coeff_we_i = 1'b0;
        coeff_addr_i = '0; coeff_data_i = '0; overrun_clr_i = 1'b0;
        test_reset();
        test_impulse(NT);
        test_random();
        test_overrun();
        test_write_busy();
`ifdef DEMOD_SCHED_COEFF_WR_EN
        test_gain();
        test_saturation();
`else
        test_write_ignored();
`endif
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/demod_fir_scheduler.md
Name: demod_fir_scheduler

Overview:
Time-multiplexed low-pass filter engine for the QPD demodulator. It replaces four parallel FIR instances with one shared multiply-accumulate. On each sample tick it captures the four mixer products (diff·sin, diff·cos, sum·sin, sum·cos), sequences NUM_TAPS MACs per channel, and publishes x1/x2/i1/i2 with a single done pulse. It also owns the writable coefficient bank.

Parameters:
NUM_BITS, 24, sample/coeff/output width (signed)
NUM_TAPS, 41, taps per channel
NUM_CH, 4, channels sharing the MAC
COEFF_FRAC, 23, fractional bits of coefficients (Q1.23); output shift

Ports:
clk_i  in  1  clock
reset_ni  in  1  asynchronous, active-low reset
tick_i  in  1  new-sample strobe, one cycle
ch_i  in  NUM_CH*NUM_BITS  channel c at bits [c*NUM_BITS +: NUM_BITS], signed
coeff_we_i  in  1  coefficient write strobe
coeff_addr_i  in  $clog2(NUM_TAPS)  tap index
coeff_data_i  in  NUM_BITS  signed coefficient
overrun_clr_i  in  1  clears overrun_o
y_o  out  NUM_CH*NUM_BITS  filtered outputs, same packing as ch_i
done_o  out  1  one-cycle pulse: y_o updated
busy_o  out  1  high from CAPTURE through DONE
overrun_o  out  1  sticky: tick_i arrived while busy

Behaviour:
- Reset (async, reset_ni=0): FSM=IDLE; y_o=0; done_o=0; busy_o=0; overrun_o=0; history=0; wr_ptr=0; accumulator=0; coefficients = package default DEMOD_LPF_COEFFS. A reset mid-run aborts the run; no done pulse follows.
- History: per-channel ring of NUM_TAPS samples with a shared wr_ptr that wraps NUM_TAPS-1 -> 0.
- States:
  - IDLE -> CAPTURE on tick_i.
  - CAPTURE (1 cycle): write ch_i to hist[c][wr_ptr] for all c; set ch=0, k=0.
  - MAC (NUM_TAPS cycles): issue hist[ch][(wr_ptr-k) mod NUM_TAPS] * coeff[k]. Here k=0 is the newest sample.
  - DRAIN (2 cycles): flush the 2-stage pipeline (operand reg -> product reg -> acc).
  - STORE (1 cycle): latch the channel result internally; clear acc. If ch<NUM_CH-1, ch++ and go to MAC; else go to DONE.
  - DONE (1 cycle): update all y_o at once; pulse done_o; advance wr_ptr; go to IDLE.
- Latency: tick sampled at edge E0 -> done_o high for the one cycle following edge E0+L, with L = 2 + NUM_CH*(NUM_TAPS+3) = 178 at defaults. Throughput: one tick per L+1 cycles.
- Arithmetic:
  - product is 2*NUM_BITS wide.
  - acc is 2*NUM_BITS+$clog2(NUM_TAPS) bits (54 at defaults); no acc overflow is possible.
  - y = acc >>> COEFF_FRAC (floor), saturated to [-2^(NUM_BITS-1), 2^(NUM_BITS-1)-1].
- tick_i while busy_o=1 (including the DONE cycle): ignored; set overrun_o. wr_ptr and history are unchanged.
- overrun_clr_i and a new overrun in the same cycle: set wins.
- Coefficient writes are accepted only in IDLE and are ignored in any other state.
  - coeff_addr_i >= NUM_TAPS: ignored.
  - Write and tick_i in the same IDLE cycle: the write lands, and the triggered run uses the new value.

Optional Feature:
DEMOD_SCHED_COEFF_WR_EN
- Defined: coefficient write port is live as described above.
- Undefined: coefficients are constants from DEMOD_LPF_COEFFS. coeff_we_i, coeff_addr_i and coeff_data_i are ignored (ports remain), and no coefficient registers are inferred.

Decomposition:
- Package demod_pkg holds:
  - DEMOD_LPF_COEFFS (41-entry symmetric lowpass, Q1.23, centre tap 2487678, first tap -1160);
  - sched_state_e enum (IDLE, CAPTURE, MAC, DRAIN, STORE, DONE);
  - derived width constants ACC_BITS and TAP_IDX_BITS.
- One natural sub-module: demod_mac_pipe. It holds the 2-stage multiply/accumulate with clear and saturate-shift output. The FSM, history rings and coefficient bank stay in the top.

Test Plan:
- Impulse: after reset, tick with ch0=4194304 and ch1..3=0, then 40 zero ticks -> y0 per tick = floor(c[k]/2): -580, -2126, -2994, -125, 7227 ...; y1..3=0; done_o exactly 178 cycles after each tick.
- Gain (WR_EN on): write c[0]=8388607 and all other taps 0, then tick ch=1000000 on all channels -> every y = 999999. Same test with -1000000 -> -1000000.
- Saturation (WR_EN on): all taps 8388607, 41 ticks of 8388607 -> y=8388607; 41 ticks of -8388608 -> y=-8388608.
- Overrun: ticks at cycle 0 and cycle 50 -> a single done_o at 178; overrun_o=1 from cycle 51; the next impulse response shows wr_ptr advanced once. overrun_clr_i -> overrun_o=0.
- Reset mid-run: reset_ni low at cycle 100 -> y_o=0, busy_o=0, done_o=0 asynchronously; no done_o afterwards. Coefficients revert to default, confirmed by rerunning the impulse test.
- Write while busy: coeff write at cycle 60 of a run -> ignored; subsequent output matches the unmodified coefficients.
